// File: rtl/ccc_upload_pkg.sv
// Shared types and constants for the HPS upload byte server.
// FSM states, the byte returned for out-of-range reads, and the memory-latency limits.
package ccc_upload_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAITQ = 2'd2
  } state_e;

  localparam logic [7:0] FILL_BYTE   = 8'hFF;
  localparam int         MEM_LAT_MIN = 1;
  localparam int         MEM_LAT_MAX = 7;
  localparam int         LAT_W       = 3;

  // Countdown start value: the latency is clamped into its legal range, then reduced by one
  // so the counter reaches zero in the last cycle of WAITQ.
  function automatic logic [LAT_W-1:0] lat_load(input int lat);
    int l;
    l = (lat < MEM_LAT_MIN) ? MEM_LAT_MIN : ((lat > MEM_LAT_MAX) ? MEM_LAT_MAX : lat);
    return LAT_W'(l - 1);
  endfunction

endpackage

// File: rtl/ccc_upload_lat_pipe.sv
// Down-counter that measures the memory read latency after a fetch.
// It loads on load_i. done_o is high in the last WAITQ cycle, when the counter reaches terminal count.
module upload_lat_pipe
  import ccc_upload_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic load_i,
  input  logic count_i,
  output logic done_o
);

  logic [LAT_W-1:0] cnt_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= lat_load(MEM_LAT);
    end else if (count_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - LAT_W'(1);
    end
  end

  assign done_o = count_i && (cnt_q == '0);

endmodule

// File: rtl/ccc_upload.sv
// Serves HPS upload byte requests from cartridge/RAM. Reads outside the image return a fill byte.
// Defining CCC_UPLOAD_CHECKSUM_EN adds a running mod-256 checksum of the delivered bytes.
//   state    | meaning
//   ST_IDLE  | waiting for ioctl_rd
//   ST_FETCH | mem_rd pulse issued
//   ST_WAITQ | counting down memory latency
module ccc_upload
  import ccc_upload_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  input  logic [ADDR_W:0]   image_len,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_q,
  output logic [ADDR_W:0]   bytes_sent,
  output logic              proto_err
`ifdef CCC_UPLOAD_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  state_e            state_q;
  logic [7:0]        din_q;
  logic              mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W:0]   bytes_q, bytes_d;
  logic              perr_q;
  logic              upload_q;

  logic in_range, rd_idle, start, fill, upload_rise, lat_done, deliver;

  assign in_range    = {1'b0, ioctl_addr} < image_len;
  assign rd_idle     = ioctl_rd && ioctl_upload && (state_q == ST_IDLE);
  assign start       = rd_idle && in_range;
  assign fill        = rd_idle && !in_range;
  assign upload_rise = ioctl_upload && !upload_q;
  assign deliver     = (state_q == ST_WAITQ) && ioctl_upload && lat_done;
  assign bytes_d     = (&bytes_q) ? bytes_q : bytes_q + (ADDR_W+1)'(1);

  upload_lat_pipe #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk_sys (clk_sys),
    .reset   (reset),
    .load_i  (state_q == ST_FETCH),
    .count_i (state_q == ST_WAITQ),
    .done_o  (lat_done)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      din_q      <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      bytes_q    <= '0;
      perr_q     <= 1'b0;
      upload_q   <= 1'b0;
    end else begin
      upload_q <= ioctl_upload;
      mem_rd_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_FETCH;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= ioctl_addr;
          end else if (fill) begin
            din_q <= FILL_BYTE;
          end
        end
        ST_FETCH: state_q <= ioctl_upload ? ST_WAITQ : ST_IDLE;
        ST_WAITQ: begin
          // If the upload session is dropped, the fetch is abandoned and its data is never used.
          if (!ioctl_upload) begin
            state_q <= ST_IDLE;
          end else if (lat_done) begin
            state_q <= ST_IDLE;
            din_q   <= mem_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (upload_rise) begin
        bytes_q <= '0;
        perr_q  <= 1'b0;
      end else begin
        if (deliver) bytes_q <= bytes_d;
        if (ioctl_rd && (state_q != ST_IDLE)) perr_q <= 1'b1;
      end
    end
  end

`ifdef CCC_UPLOAD_CHECKSUM_EN
  logic [7:0] cks_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cks_q <= '0;
    end else if (upload_rise) begin
      cks_q <= '0;
    end else if (deliver) begin
      cks_q <= cks_q + mem_q;
    end
  end

  assign checksum = cks_q;
`endif

  assign ioctl_wait = !reset && (start || (state_q != ST_IDLE));
  assign ioctl_din  = din_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign bytes_sent = bytes_q;
  assign proto_err  = perr_q;

endmodule
